// File: rtl/wb_result_stage_if.sv
// wb_result_stage_if: bundles the MEM->WB pipeline inputs and the writeback outputs.
//   master: pipeline side; drives StallW/FlushW and the M-stage fields, observes W outputs.
//   slave : writeback stage; consumes M-stage fields, drives ResultW/RdW/RegWriteW/ValidW/RetireCount.
// Parameters must match those of the wb_result_stage instance the interface is bound to.
interface wb_result_stage_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NSRC  = 4,
  parameter int unsigned CNTW  = 32
);
  localparam int unsigned SELW = (NSRC > 1) ? $clog2(NSRC) : 1;

  // hazard-unit controls
  logic                    StallW;
  logic                    FlushW;
  // M-stage payload
  logic                    ValidM;
  logic                    RegWriteM;
  logic [4:0]              RdM;
  logic [SELW-1:0]         ResultSrcM;
  logic [2:0]              Funct3M;
  logic [NSRC*WIDTH-1:0]   SrcM;
  // writeback outputs
  logic [WIDTH-1:0]        ResultW;
  logic [4:0]              RdW;
  logic                    RegWriteW;
  logic                    ValidW;
  logic [CNTW-1:0]         RetireCount;

  modport master (
    output StallW, FlushW, ValidM, RegWriteM, RdM, ResultSrcM, Funct3M, SrcM,
    input  ResultW, RdW, RegWriteW, ValidW, RetireCount
  );

  modport slave (
    input  StallW, FlushW, ValidM, RegWriteM, RdM, ResultSrcM, Funct3M, SrcM,
    output ResultW, RdW, RegWriteW, ValidW, RetireCount
  );
endinterface

// File: rtl/wb_result_stage.sv
// wb_result_stage: RV32I writeback stage. MEM/WB pipeline register followed by an
// NSRC-way result select; slot 0 = ALU result (also supplies the load byte offset),
// slot 1 = load data, slots 2..NSRC-1 free. Counts every valid instruction entering W.
// Ports:
//   clk   - clock, rising edge
//   reset - asynchronous, active-high, clears all state
//   bus   - wb_result_stage_if.slave (StallW/FlushW, M-stage fields in, W outputs out)
// Optional feature macro: WB_LOAD_EXT_EN
//   defined   - slot 1 gets lb/lh/lw/lbu/lhu extraction and sign/zero extension
//   undefined - slot 1 passes unmodified; Funct3M is ignored and not registered
module wb_result_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NSRC  = 4,
  parameter int unsigned CNTW  = 32
) (
  input logic              clk,
  input logic              reset,
  wb_result_stage_if.slave bus
);
  localparam int unsigned SELW = (NSRC > 1) ? $clog2(NSRC) : 1;
  localparam int unsigned SRCW = NSRC * WIDTH;

  logic              valid_q;
  logic              regwrite_q;
  logic [4:0]        rd_q;
  logic [SELW-1:0]   sel_q;
  logic [SRCW-1:0]   src_q;
  logic [CNTW-1:0]   count_q;
  logic [WIDTH-1:0]  ld_data;
  logic [WIDTH-1:0]  result;
  logic              load_en;

  assign load_en = !bus.FlushW && !bus.StallW;

  // Control fields: flush clears them so a bubble never writes back.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      rd_q       <= 5'd0;
    end else if (bus.FlushW) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      rd_q       <= 5'd0;
    end else if (!bus.StallW) begin
      valid_q    <= bus.ValidM;
      regwrite_q <= bus.RegWriteM;
      rd_q       <= bus.RdM;
    end
  end

  // Data fields: left untouched by a flush since a bubble's result is never consumed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_q <= '0;
      src_q <= '0;
    end else if (load_en) begin
      sel_q <= bus.ResultSrcM;
      src_q <= bus.SrcM;
    end
  end

  // Retire counter: counted once on entry, so a held stall is not recounted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (load_en && bus.ValidM) begin
      count_q <= count_q + CNTW'(1);
    end
  end

`ifdef WB_LOAD_EXT_EN
  logic [2:0]  funct3_q;
  logic [31:0] ld_word;
  logic [15:0] ld_half;
  logic [7:0]  ld_byte;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      funct3_q <= 3'b000;
    end else if (load_en) begin
      funct3_q <= bus.Funct3M;
    end
  end

  // Byte offset comes from the ALU address in slot 0; halfword ignores off[0].
  always_comb begin
    ld_word = src_q[WIDTH +: 32];
    ld_half = ld_word[15:0];
    ld_byte = ld_word[7:0];
    ld_data = WIDTH'(ld_word);
    if (src_q[1]) ld_half = ld_word[31:16];
    case (src_q[1:0])
      2'd1:    ld_byte = ld_word[15:8];
      2'd2:    ld_byte = ld_word[23:16];
      2'd3:    ld_byte = ld_word[31:24];
      default: ld_byte = ld_word[7:0];
    endcase
    case (funct3_q)
      3'b000:  ld_data = WIDTH'($signed(ld_byte));
      3'b001:  ld_data = WIDTH'($signed(ld_half));
      3'b100:  ld_data = WIDTH'(ld_byte);
      3'b101:  ld_data = WIDTH'(ld_half);
      default: ld_data = WIDTH'(ld_word);
    endcase
  end
`else
  logic unused_funct3;

  assign unused_funct3 = ^bus.Funct3M;
  assign ld_data       = src_q[WIDTH +: WIDTH];
`endif

  // Result select; an index with no matching slot (NSRC not a power of two) yields 0.
  always_comb begin
    result = '0;
    for (int unsigned k = 0; k < NSRC; k++) begin
      if (32'(sel_q) == k) begin
        result = (k == 1) ? ld_data : src_q[k*WIDTH +: WIDTH];
      end
    end
  end

  assign bus.ResultW     = result;
  assign bus.RdW         = rd_q;
  assign bus.ValidW      = valid_q;
  assign bus.RegWriteW   = regwrite_q && valid_q && (rd_q != 5'd0);
  assign bus.RetireCount = count_q;
endmodule
